// File: rtl/simon_playback_timer_if.sv
// Handshake/bus bundle between the Simon controller and the playback timer.
// Ports: start/abort/last_addr (and pause when PLAYBACK_PAUSE_EN is defined) flow
// controller -> timer; rd_addr/led_en/busy/done flow timer -> controller/storage.
interface simon_playback_timer_if #(
  parameter int ADDR_W = 6
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] last_addr;
`ifdef PLAYBACK_PAUSE_EN
  logic              pause;
`endif
  logic [ADDR_W-1:0] rd_addr;
  logic              led_en;
  logic              busy;
  logic              done;

  modport master (
    output start, abort, last_addr,
`ifdef PLAYBACK_PAUSE_EN
    output pause,
`endif
    input  rd_addr, led_en, busy, done
  );

  modport slave (
    input  start, abort, last_addr,
`ifdef PLAYBACK_PAUSE_EN
    input  pause,
`endif
    output rd_addr, led_en, busy, done
  );
endinterface

// File: rtl/simon_playback_timer.sv
// Paces Simon pattern playback: steps rd_addr 0..last_addr, each element shown for
// TICKS_ON cycles then blanked TICKS_OFF cycles, then a one-cycle done pulse.
// Ports: i_clk, i_rst (sync active-low), bus (slave modport of simon_playback_timer_if).
// All outputs registered; start is taken only in IDLE; abort returns to IDLE silently.
// Optional macro PLAYBACK_PAUSE_EN adds bus.pause, which freezes SHOW/GAP progress.
module simon_playback_timer #(
  parameter int TICKS_ON  = 4,
  parameter int TICKS_OFF = 2,
  parameter int CNT_W     = 8,
  parameter int ADDR_W    = 6
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  simon_playback_timer_if.slave      bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHOW   = 2'd1,
    S_GAP    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(TICKS_ON - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(TICKS_OFF - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_lim;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_led_en;
  logic              r_busy;
  logic              r_done;
  logic              w_hold;

`ifdef PLAYBACK_PAUSE_EN
  assign w_hold = bus.pause;
`else
  assign w_hold = 1'b0;
`endif

  assign bus.rd_addr = r_rd_addr;
  assign bus.led_en  = r_led_en;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

  // Outputs are set alongside each state transition so they describe the
  // state being entered, which keeps every output a plain flop.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_lim     <= '0;
      r_rd_addr <= '0;
      r_led_en  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else if (r_state != S_IDLE && bus.abort) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rd_addr <= '0;
      r_led_en  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rd_addr <= '0;
          r_led_en  <= 1'b0;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
          if (bus.start && !bus.abort) begin
            r_lim    <= bus.last_addr;
            r_cnt    <= '0;
            r_state  <= S_SHOW;
            r_led_en <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        S_SHOW: begin
          if (!w_hold) begin
            if (r_cnt == ON_LAST) begin
              r_cnt    <= '0;
              r_state  <= S_GAP;
              r_led_en <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_GAP: begin
          if (!w_hold) begin
            if (r_cnt == OFF_LAST) begin
              r_cnt <= '0;
              // Address stops at lim, so lim = all-ones never wraps to 0.
              if (r_rd_addr == r_lim) begin
                r_state <= S_FINISH;
                r_done  <= 1'b1;
              end else begin
                r_rd_addr <= r_rd_addr + ADDR_W'(1);
                r_state   <= S_SHOW;
                r_led_en  <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: begin  // S_FINISH: done was raised on entry, drop everything now
          r_state   <= S_IDLE;
          r_done    <= 1'b0;
          r_busy    <= 1'b0;
          r_rd_addr <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simon_playback_timer.sv
module tb_simon_playback_timer;
  localparam int ON  = 4;
  localparam int OFF = 2;
  localparam int P   = ON + OFF;
  localparam int AW  = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          pause = 1'b0;
  logic [AW-1:0] last_addr = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  simon_playback_timer_if #(.ADDR_W(AW)) bus ();
  assign bus.start     = start;
  assign bus.abort     = abort;
  assign bus.last_addr = last_addr;
`ifdef PLAYBACK_PAUSE_EN
  assign bus.pause     = pause;
`endif

  simon_playback_timer #(.TICKS_ON(ON), .TICKS_OFF(OFF), .CNT_W(8), .ADDR_W(AW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Reference: a playback is "cycle n of a run with lim"; outputs follow arithmetically.
  bit m_active = 1'b0;
  int m_n      = 0;
  int m_lim    = 0;

  always @(posedge clk) begin
    if (!rst) begin
      m_active <= 1'b0;
    end else if (m_active) begin
      if (abort)                               m_active <= 1'b0;
      else if (m_n == (m_lim + 1) * P + 1)     m_active <= 1'b0;
`ifdef PLAYBACK_PAUSE_EN
      else if (pause && m_n <= (m_lim + 1) * P) m_n <= m_n;
`endif
      else                                     m_n <= m_n + 1;
    end else if (start && !abort) begin
      m_active <= 1'b1;
      m_n      <= 1;
      m_lim    <= int'(last_addr);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge, then compare all outputs with the reference.
  task automatic tick();
    int e_rd, e_led, e_busy, e_done;
    @(posedge clk);
    #1;
    e_rd = 0; e_led = 0; e_busy = 0; e_done = 0;
    if (m_active) begin
      e_busy = 1;
      if (m_n <= (m_lim + 1) * P) begin
        e_rd  = (m_n - 1) / P;
        e_led = (((m_n - 1) % P) < ON) ? 1 : 0;
      end else begin
        e_rd   = m_lim;
        e_done = 1;
      end
    end
    chk("model_rd_addr", int'(bus.rd_addr), e_rd);
    chk("model_led_en",  int'(bus.led_en),  e_led);
    chk("model_busy",    int'(bus.busy),    e_busy);
    chk("model_done",    int'(bus.done),    e_done);
  endtask

  task automatic idle_gap(input int n);
    start = 0; abort = 0; pause = 0; rst = 1;
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    logic          rst;
    logic          start;
    logic          abort;
    logic [AW-1:0] last_addr;
    int            rd;
    logic          led;
    logic          busy;
    logic          done;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int done_at;
    // Reset with start held, idle after release, then a one-element run,
    // then start+abort together in IDLE.
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 6'd0, 0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 6'd0, 0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 6'd0, 0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 6'd0, 0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 6'd0, 0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 6'd0, 0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 6'd0, 0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 6'd0, 0, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 6'd0, 0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 6'd0, 0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 6'd0, 0, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 6'd0, 0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 6'd0, 0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 6'd0, 0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      rst = vecs[i].rst; start = vecs[i].start; abort = vecs[i].abort;
      last_addr = vecs[i].last_addr;
      tick();
      chk($sformatf("vec%0d_rd_addr", i), int'(bus.rd_addr), vecs[i].rd);
      chk($sformatf("vec%0d_led_en", i),  int'(bus.led_en),  int'(vecs[i].led));
      chk($sformatf("vec%0d_busy", i),    int'(bus.busy),    int'(vecs[i].busy));
      chk($sformatf("vec%0d_done", i),    int'(bus.done),    int'(vecs[i].done));
    end
    idle_gap(2);

    // Three elements: address steps every 6 cycles, done in cycle 19.
    last_addr = 6'd2; start = 1; tick(); start = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c <= 18) chk("three_rd_addr", int'(bus.rd_addr), (c <= 6) ? 0 : (c <= 12) ? 1 : 2);
      chk("three_led_en", int'(bus.led_en),
          ((c >= 1 && c <= 4) || (c >= 7 && c <= 10) || (c >= 13 && c <= 16)) ? 1 : 0);
      chk("three_done", int'(bus.done), (c == 19) ? 1 : 0);
      if (c < 20) tick();
    end
    idle_gap(2);

    // Abort during SHOW of element 1.
    last_addr = 6'd3; start = 1; tick(); start = 0;
    for (int c = 2; c <= 8; c++) tick();
    chk("abort_pre_rd_addr", int'(bus.rd_addr), 1);
    chk("abort_pre_led_en",  int'(bus.led_en),  1);
    abort = 1; tick(); abort = 0;
    chk("abort_busy",    int'(bus.busy),    0);
    chk("abort_led_en",  int'(bus.led_en),  0);
    chk("abort_rd_addr", int'(bus.rd_addr), 0);
    for (int c = 0; c < 30; c++) begin
      tick();
      chk("abort_no_done", int'(bus.done), 0);
    end

    // Restart attempt and last_addr change while running are ignored.
    last_addr = 6'd1; start = 1; tick(); start = 0;
    tick(); tick();
    last_addr = 6'd5; start = 1; tick(); start = 0;
    for (int c = 4; c <= 14; c++) begin
      chk("restart_rd_max", (bus.rd_addr <= 1) ? 1 : 0, 1);
      chk("restart_done", int'(bus.done), (c == 13) ? 1 : 0);
      if (c < 14) tick();
    end
    idle_gap(2);

    // Reset during GAP: reset values next cycle and no done afterwards.
    last_addr = 6'd0; start = 1; tick(); start = 0;
    for (int c = 2; c <= 5; c++) tick();
    chk("rstgap_pre_busy", int'(bus.busy),   1);
    chk("rstgap_pre_led",  int'(bus.led_en), 0);
    rst = 0; tick(); rst = 1;
    chk("rstgap_busy", int'(bus.busy),    0);
    chk("rstgap_led",  int'(bus.led_en),  0);
    chk("rstgap_rd",   int'(bus.rd_addr), 0);
    chk("rstgap_done", int'(bus.done),    0);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("rstgap_no_done", int'(bus.done), 0);
    end

    // Full address range: 64 elements, done in cycle 64*6+1.
    last_addr = 6'd63; start = 1; tick(); start = 0;
    done_at = -1;
    for (int c = 1; c <= 390; c++) begin
      if (c == 384) chk("lim63_last_rd", int'(bus.rd_addr), 63);
      if (bus.done && done_at < 0) done_at = c;
      if (c < 390) tick();
    end
    chk("lim63_done_cycle", done_at, 64 * P + 1);
    idle_gap(2);

`ifdef PLAYBACK_PAUSE_EN
    // Pause in cycles 2-4 stretches display by three cycles.
    last_addr = 6'd0; start = 1; tick(); start = 0;
    for (int c = 1; c <= 11; c++) begin
      chk("pause_led_en", int'(bus.led_en), (c <= 7) ? 1 : 0);
      chk("pause_done",   int'(bus.done),   (c == 10) ? 1 : 0);
      pause = (c >= 2 && c <= 4);
      if (c < 11) tick();
    end
    pause = 0;
    idle_gap(2);
`endif

    // Random traffic against the reference.
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 149) != 0);
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 19) == 0) last_addr = AW'($urandom_range(0, 63));
      else                            last_addr = AW'($urandom_range(0, 3));
`ifdef PLAYBACK_PAUSE_EN
      pause = ($urandom_range(0, 5) == 0);
`endif
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/simon_playback_timer.md
Name: simon_playback_timer

Overview:
Paces the PLAYBACK phase of the Simon game so that a stored pattern is shown at a human-visible rate. The Simon controller pulses start when it enters playback. The block steps the pattern-storage read address through elements 0..last_addr, showing each one for TICKS_ON cycles followed by a TICKS_OFF blank gap. It then returns a one-cycle done pulse, which the controller uses to advance to REPEAT mode.

Parameters:
TICKS_ON, 4, cycles each element is displayed; legal range 1 to 2^CNT_W-1
TICKS_OFF, 2, blank cycles after each element; legal range 1 to 2^CNT_W-1
CNT_W, 8, width of the internal tick counter
ADDR_W, 6, width of the pattern-storage address

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk
start  input  1  begin playback; honoured only in IDLE
abort  input  1  cancel playback; return to IDLE with no done pulse
last_addr  input  ADDR_W  index of the last stored element (pattern length minus 1)
rd_addr  output  ADDR_W  read address driven to pattern storage
led_en  output  1  high while the current element is to be displayed
busy  output  1  high in SHOW, GAP and FINISH
done  output  1  one-cycle pulse at the end of playback

Behaviour:
- All outputs are registered. Notation: cycle n is the state after the n-th rising edge following the edge that sampled start.
- Reset (rst=0 at an edge): state=IDLE, tick counter=0, rd_addr=0, led_en=0, busy=0, done=0. Reset overrides every other input, including start and abort in the same cycle.
- IDLE
  - rd_addr=0, led_en=0, busy=0.
  - If start=1 and abort=0: latch last_addr into lim, clear the tick counter, go to SHOW.
- SHOW
  - led_en=1, busy=1.
  - The tick counter increments each cycle.
  - When the counter reaches TICKS_ON-1: clear it and go to GAP.
- GAP
  - led_en=0, busy=1.
  - When the counter reaches TICKS_OFF-1:
    - if rd_addr==lim: go to FINISH;
    - else: rd_addr+1, clear the counter, go to SHOW.
- FINISH
  - done=1, busy=1, led_en=0 for exactly one cycle, then IDLE.
- Timing: with N=lim+1 elements, led_en is high in cycles k*(TICKS_ON+TICKS_OFF)+1 .. k*(TICKS_ON+TICKS_OFF)+TICKS_ON, for k=0..N-1. done is high in cycle N*(TICKS_ON+TICKS_OFF)+1. busy falls the following cycle.
- start while not in IDLE is ignored; it does not restart the sequence.
- last_addr changes after latching are ignored until the next start.
- rd_addr never wraps: it stops at lim. lim = 2^ADDR_W-1 is legal and plays every address.
- abort=1 in any non-IDLE state → next cycle is IDLE with rd_addr=0, led_en=0, busy=0, done=0.
- abort=1 in FINISH suppresses nothing: done has already been asserted that cycle.
- start and abort both high in IDLE: abort wins and the block stays in IDLE.
- Reset mid-operation: reset values take effect at the next edge; no done pulse is produced.
- Tick counter arithmetic is unsigned, CNT_W bits, and is compared by equality only.

Optional Feature:
Macro PLAYBACK_PAUSE_EN.
- Defined:
  - Adds input pause (1 bit).
  - While pause=1 in SHOW or GAP: the tick counter, rd_addr, state and led_en hold their values.
  - pause has no effect in IDLE or FINISH.
  - abort and rst override pause.
  - Overall timing stretches by exactly the number of paused cycles.
- Not defined: the port does not exist and timing is as above.

Test Plan:
(All with defaults TICKS_ON=4, TICKS_OFF=2.)
1. Hold rst=0 for 2 edges with start=1 → rd_addr=0, led_en=0, busy=0, done=0; state stays IDLE after rst=1 until a fresh start.
2. last_addr=0, pulse start → led_en=1 in cycles 1-4, 0 in cycles 5-6; done=1 only in cycle 7; busy=0 in cycle 8; rd_addr=0 throughout.
3. last_addr=2, pulse start → rd_addr=0 in cycles 1-6, 1 in cycles 7-12, 2 in cycles 13-18; led_en high in cycles 1-4, 7-10 and 13-16; done=1 in cycle 19.
4. last_addr=3, start, then abort=1 sampled in cycle 8 (SHOW of element 1) → cycle 9 has busy=0, led_en=0, rd_addr=0; done never asserts.
5. last_addr=1, start; in cycle 3 set last_addr=5 and pulse start again → both ignored; done=1 in cycle 13; rd_addr never exceeds 1.
6. With PLAYBACK_PAUSE_EN: last_addr=0, start, pause=1 during cycles 2-4 → led_en high in cycles 1-7, done=1 in cycle 10. Separately, rst=0 mid-GAP → all outputs at reset values next cycle, no done.
